// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous ripple-counter value into the clk domain, filters ripple
// transients, and reports the accepted count plus wrap/skip/match events.
module ripple_count_sampler #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] match_val,
    input  logic             clr_wraps,
    output logic [WIDTH-1:0] count_q,
    output logic             count_valid,
    output logic             wrap_pulse,
    output logic             skip_pulse,
    output logic             match_pulse,
    output logic [7:0]       wrap_cnt
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned WC_W   = 8;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_ACC = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [WC_W-1:0]   WC_MAX   = '1;

    typedef enum logic {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  s1_q, s2_q, s3_q;
    logic [2:0]        fill_q;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [WIDTH-1:0]  count_d;
    logic              valid_d, wrap_d, skip_d, match_d;
    logic [WC_W-1:0]   wrap_cnt_d;
    logic              same_c, acc_c;
    logic [WIDTH-1:0]  delta_c;

    // fill_q keeps the reset contents of the pipe from counting as a sampled value
    assign same_c  = fill_q[2] && (s2_q == s3_q);
    assign acc_c   = enable && same_c && ((stab_q == STAB_ACC) || (stab_q == STAB_MAX))
                     && ((state_q == ACQUIRE) || (s2_q != count_q));
    assign delta_c = s2_q - count_q;

    always_comb begin
        state_d    = state_q;
        stab_d     = '0;
        count_d    = count_q;
        valid_d    = count_valid;
        wrap_d     = 1'b0;
        skip_d     = 1'b0;
        match_d    = 1'b0;
        wrap_cnt_d = wrap_cnt;

        if (same_c) begin
            stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + STAB_W'(1);
        end

        if (acc_c) begin
            count_d = s2_q;
            valid_d = 1'b1;
            match_d = (s2_q == match_val);
            if (state_q == TRACK) begin
                wrap_d = (s2_q < count_q);
                skip_d = (delta_c > WIDTH'(1));
            end else begin
                state_d = TRACK;
            end
        end

        // wrap_cnt moves on the same edge that raises wrap_pulse; clear wins
        if (clr_wraps) begin
            wrap_cnt_d = '0;
        end else if (wrap_d && (wrap_cnt != WC_MAX)) begin
            wrap_cnt_d = wrap_cnt + WC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ACQUIRE;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            fill_q      <= '0;
            stab_q      <= '0;
            count_q     <= '0;
            count_valid <= 1'b0;
            wrap_pulse  <= 1'b0;
            skip_pulse  <= 1'b0;
            match_pulse <= 1'b0;
            wrap_cnt    <= '0;
        end else begin
            state_q     <= state_d;
            s1_q        <= cnt_in;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            fill_q      <= {fill_q[1:0], 1'b1};
            stab_q      <= stab_d;
            count_q     <= count_d;
            count_valid <= valid_d;
            wrap_pulse  <= wrap_d;
            skip_pulse  <= skip_d;
            match_pulse <= match_d;
            wrap_cnt    <= wrap_cnt_d;
        end
    end

endmodule
